// File: rtl/block_hit_ctrl.sv
// rtl/block_hit_ctrl.sv - block-state RAM port A owner: level fill, read-test-clear hits, score/blocks tracking
// Optional BLOCK_HIT_BONUS_EN: the hit that clears the last block also adds LEVEL_BONUS to SCORE.
module block_hit_ctrl #(
  parameter int NUM_BLOCKS  = 73,
  parameter int SCORE_W     = 16,
  parameter int LEVEL_BONUS = 50
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               HIT_REQ,
  input  logic [6:0]         HIT_ADDR,
  input  logic               NEW_LEVEL,
  output logic               BUSY,
  output logic               HIT_ACK,
  output logic               HIT_WAS_SET,
  output logic [6:0]         A_ADDR,
  output logic               A_WRITE_ENABLE,
  output logic               A_IN,
  input  logic               A_OUT,
  output logic [SCORE_W-1:0] SCORE,
  output logic [6:0]         BLOCKS_LEFT,
  output logic               LEVEL_CLEAR
);

  typedef enum logic [1:0] {INIT, IDLE, RD, CHK} state_t;
  typedef logic [SCORE_W:0] sum_t;

  localparam sum_t       HIT_INC    = sum_t'(1);
  localparam sum_t       CLEAR_INC  = sum_t'(1 + LEVEL_BONUS);
  localparam logic [6:0] LAST_ADDR  = 7'(NUM_BLOCKS - 1);
  localparam logic [6:0] FULL_COUNT = 7'(NUM_BLOCKS);

  state_t     state;
  logic [6:0] ptr;
  logic [6:0] hit_addr;
  logic       refill_pending;
  logic       take_bonus;
  logic       hit;
  sum_t       score_sum;

`ifdef BLOCK_HIT_BONUS_EN
  assign take_bonus = (BLOCKS_LEFT == 7'd1);
`else
  assign take_bonus = 1'b0;
`endif

  // The count guard keeps BLOCKS_LEFT from wrapping even if the RAM disagrees with it.
  assign hit       = (hit_addr <= LAST_ADDR) && A_OUT && (BLOCKS_LEFT != 7'd0);
  assign score_sum = {1'b0, SCORE} + (take_bonus ? CLEAR_INC : HIT_INC);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= INIT;
      ptr            <= 7'd0;
      hit_addr       <= 7'd0;
      refill_pending <= 1'b0;
      A_ADDR         <= 7'd0;
      A_WRITE_ENABLE <= 1'b0;
      A_IN           <= 1'b0;
      BUSY           <= 1'b1;
      HIT_ACK        <= 1'b0;
      HIT_WAS_SET    <= 1'b0;
      SCORE          <= '0;
      BLOCKS_LEFT    <= 7'd0;
      LEVEL_CLEAR    <= 1'b0;
    end else begin
      HIT_ACK     <= 1'b0;
      HIT_WAS_SET <= 1'b0;
      if (NEW_LEVEL && state != IDLE) begin
        refill_pending <= 1'b1;
      end
      case (state)
        INIT: begin
          A_ADDR         <= ptr;
          A_WRITE_ENABLE <= 1'b1;
          A_IN           <= 1'b1;
          LEVEL_CLEAR    <= 1'b0;
          if (ptr == LAST_ADDR) begin
            ptr         <= 7'd0;
            BLOCKS_LEFT <= FULL_COUNT;
            BUSY        <= 1'b0;
            state       <= IDLE;
          end else begin
            ptr  <= ptr + 7'd1;
            BUSY <= 1'b1;
          end
        end
        IDLE: begin
          A_WRITE_ENABLE <= 1'b0;
          A_IN           <= 1'b0;
          // A refill outranks a hit; the held request is served once the sweep ends.
          if (refill_pending || NEW_LEVEL) begin
            refill_pending <= 1'b0;
            ptr            <= 7'd0;
            BUSY           <= 1'b1;
            LEVEL_CLEAR    <= 1'b0;
            state          <= INIT;
          end else if (HIT_REQ) begin
            hit_addr    <= HIT_ADDR;
            A_ADDR      <= HIT_ADDR;
            BUSY        <= 1'b1;
            LEVEL_CLEAR <= 1'b0;
            state       <= RD;
          end else begin
            LEVEL_CLEAR <= (BLOCKS_LEFT == 7'd0);
          end
        end
        RD: begin
          A_ADDR         <= hit_addr;
          A_WRITE_ENABLE <= 1'b0;
          state          <= CHK;
        end
        CHK: begin
          HIT_ACK     <= 1'b1;
          HIT_WAS_SET <= hit;
          BUSY        <= 1'b0;
          state       <= IDLE;
          if (hit) begin
            A_WRITE_ENABLE <= 1'b1;
            A_IN           <= 1'b0;
            BLOCKS_LEFT    <= BLOCKS_LEFT - 7'd1;
            SCORE          <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            LEVEL_CLEAR    <= (BLOCKS_LEFT == 7'd1);
          end else begin
            LEVEL_CLEAR <= (BLOCKS_LEFT == 7'd0);
          end
        end
      endcase
    end
  end

endmodule
